// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: instruction field layout,
// FSM state encoding and the default halt opcode.
package instr_sequencer_pkg;

  localparam int INSTR_W = 15;

  localparam int FUNC_HI = 14;
  localparam int FUNC_LO = 12;
  localparam int RX_HI   = 11;
  localparam int RX_LO   = 8;
  localparam int RY_HI   = 7;
  localparam int RY_LO   = 4;
  localparam int DATA_HI = 3;
  localparam int DATA_LO = 0;

  localparam logic [2:0] HALT_FUNC_DEFAULT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: DEPTH x INSTR_W register array, cleared by reset, one write
// port and one registered read port. A same-cycle write to the address being
// read is forwarded so a freshly loaded word is visible immediately.
module seq_prog_mem
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [INSTR_W-1:0] rd_data_p0
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Storage array: erased on reset, written one word per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read with write-through forwarding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_p0 <= '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_data_p0 <= wr_data;
    end else begin
      rd_data_p0 <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches packed instructions in order, issues them to
// the register/ALU datapath with a one-cycle w strobe and waits for the
// datapath to report idle before moving on. Ends on halt, end of memory,
// abort or timeout.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter int         ADDR_W    = 4,
  parameter logic [4:0] IDLE_CODE = 5'd0,
  parameter logic [2:0] HALT_FUNC = HALT_FUNC_DEFAULT,
  parameter int         TIMEOUT   = 63
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic               start,
  input  logic               abort,
  input  logic [4:0]         dp_state,
  output logic [2:0]         func,
  output logic [3:0]         rx,
  output logic [3:0]         ry,
  output logic [3:0]         data,
  output logic               w,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int TIMER_W = 6;

  seq_state_t         state, state_d;
  logic [ADDR_W-1:0]  pc_d;
  logic [TIMER_W-1:0] timer, timer_d;
  logic               done_d, error_d, fetch;
  logic [INSTR_W-1:0] rd_data_p0;
  logic [INSTR_W-1:0] instr_p1;
  logic               timed_out;

  // The read port is addressed with the next pc so that mem[pc] is already
  // sitting in rd_data_p0 during FETCH, letting the halt check happen there.
  seq_prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prog_mem (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (load_en && !busy),
    .wr_addr    (load_addr),
    .wr_data    (load_instr),
    .rd_addr    (pc_d),
    .rd_data_p0 (rd_data_p0)
  );

  assign timed_out = (timer == TIMER_W'(TIMEOUT));

  // Next-state, pc, timer and status-flag decisions.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    timer_d = timer;
    done_d  = done;
    error_d = error;
    fetch   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_d = ST_FETCH;
            pc_d    = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
          end
        end
        ST_FETCH: begin
          fetch = 1'b1;
          if (rd_data_p0[FUNC_HI:FUNC_LO] == HALT_FUNC) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_d = ST_WAIT_ACK;
          timer_d = '0;
        end
        ST_WAIT_ACK: begin
          if (dp_state != IDLE_CODE) begin
            state_d = ST_WAIT_DONE;
            timer_d = '0;
          end else if (timed_out) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            timer_d = timer + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (dp_state == IDLE_CODE) begin
            if (pc == ADDR_W'(DEPTH - 1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              pc_d    = pc + 1'b1;
              state_d = ST_FETCH;
            end
          end else if (timed_out) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            timer_d = timer + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, pc, timer, flags and the held instruction register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      pc       <= '0;
      timer    <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      instr_p1 <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      timer <= timer_d;
      done  <= done_d;
      error <= error_d;
      if (fetch) begin
        instr_p1 <= rd_data_p0;
      end
    end
  end

  assign func = instr_p1[FUNC_HI:FUNC_LO];
  assign rx   = instr_p1[RX_HI:RX_LO];
  assign ry   = instr_p1[RY_HI:RY_LO];
  assign data = instr_p1[DATA_HI:DATA_LO];
  assign w    = (state == ST_ISSUE);
  assign busy = (state == ST_FETCH) || (state == ST_ISSUE) ||
                (state == ST_WAIT_ACK) || (state == ST_WAIT_DONE);

endmodule
